// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus word-RAM port of the load/store access controller.
// The controller takes the slave side; the requester and RAM model take the master side.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_wd;
  logic [DATA_WIDTH-1:0] ram_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, ram_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_a, ram_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, ram_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_a, ram_wd
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller in front of a word-wide RAM.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_t;

  state_t                state_q, state_d;
  logic                  we_q;
  size_t                 size_q;
  logic                  unsigned_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rbuf_q;

  logic                  req_ready;
  logic                  accept;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = bus.req_valid && req_ready;
  assign misaligned = (bus.req_size == SZ_ILL)
                   || (bus.req_size == SZ_HALF && bus.req_addr[0])
                   || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (misaligned)                        state_d = RESP;
        else if (!bus.req_we)                  state_d = READ;
        else if (bus.req_size == SZ_WORD)      state_d = WRITE;
        else                                   state_d = READ;
      end
      READ:  state_d = we_q ? WRITE : RESP;
      WRITE: state_d = RESP;
      RESP:  if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
    end else begin
      if (accept) begin
        we_q       <= bus.req_we;
        size_q     <= size_t'(bus.req_size);
        unsigned_q <= bus.req_unsigned;
        err_q      <= misaligned;
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
      end
      if (state_q == READ) rbuf_q <= bus.ram_rd;
    end
  end

  assign aligned_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign shifted      = rbuf_q >> {addr_q[1:0], 3'b000};

  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    load_data = rbuf_q;
    merged    = wdata_q;
    unique case (size_q)
      SZ_BYTE: begin
        load_data = {{(DATA_WIDTH-8){shifted[7] & ~unsigned_q}}, shifted[7:0]};
        merged    = rbuf_q;
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_data = {{(DATA_WIDTH-16){shifted[15] & ~unsigned_q}}, shifted[15:0]};
        merged    = rbuf_q;
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  // Outputs are pure decodes of state, so reset clears them the moment state_q returns to IDLE.
  always_comb begin
    bus.req_ready  = req_ready;
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.resp_rdata = (state_q == RESP && !err_q && !we_q) ? load_data : '0;
    bus.ram_we     = (state_q == WRITE);
    bus.ram_a      = (state_q == READ || state_q == WRITE) ? aligned_addr : '0;
    bus.ram_wd     = (state_q == WRITE) ? merged : '0;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a 16-word RAM model behind the controller and
// hand-computed expectations for stores, read-modify-writes, loads, errors, stalls and reset abort.
module tb_mem_access_ctrl;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [16];
  int          wr_count = 0;
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'd0;

  mem_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.ram_rd = mem[bus.ram_a[5:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.ram_we === 1'b1) begin
      mem[bus.ram_a[5:2]] <= bus.ram_wd;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_idx = idx[3:0];
    poke_val = val;
    poke_en  = 1'b1;
    step();
    poke_en  = 1'b0;
  endtask

  // Presents one request and returns just after its acceptance edge.
  task automatic accept(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    check("req_ready_before_accept", bus.req_ready, 1'b1);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    step();
    bus.req_valid    = 1'b0;
    bus.req_wdata    = 32'hFFFF_FFFF;
  endtask

  task automatic finish_resp(input string tag);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check({tag, "_resp_done"}, bus.resp_valid, 1'b0);
    check({tag, "_ready_again"}, bus.req_ready, 1'b1);
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] aligned;
    aligned = {addr[31:2], 2'b00};
    accept(1'b0, size, uns, addr, 32'h0);
    check({tag, "_read_ram_a"}, bus.ram_a, aligned);
    check({tag, "_read_no_resp"}, bus.resp_valid, 1'b0);
    step();
    check({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
    check({tag, "_rdata"}, bus.resp_rdata, exp);
    check({tag, "_err"}, bus.resp_err, 1'b0);
    finish_resp(tag);
  endtask

  task automatic bad_req(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr);
    int wr0;
    wr0 = wr_count;
    accept(we, size, 1'b0, addr, 32'h1234_5678);
    check({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
    check({tag, "_err"}, bus.resp_err, 1'b1);
    check({tag, "_rdata"}, bus.resp_rdata, 32'h0);
    check({tag, "_ram_we"}, bus.ram_we, 1'b0);
    finish_resp(tag);
    check({tag, "_no_write"}, wr_count - wr0, 32'd0);
  endtask

  initial begin
    int wr0;
    rst = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.resp_ready   = 1'b0;

    #1;
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_ram_a", bus.ram_a, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("first_cycle_ready", bus.req_ready, 1'b1);

    poke(0, 32'h1122_3344);
    poke(1, 32'h0);

    // Word store then word load at the same address.
    wr0 = wr_count;
    accept(1'b1, SZ_W, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF);
    check("wst_ram_we", bus.ram_we, 1'b1);
    check("wst_ram_a", bus.ram_a, 32'h0001_0004);
    check("wst_ram_wd", bus.ram_wd, 32'hDEAD_BEEF);
    check("wst_no_resp_yet", bus.resp_valid, 1'b0);
    step();
    check("wst_resp_valid", bus.resp_valid, 1'b1);
    check("wst_rdata_zero", bus.resp_rdata, 32'h0);
    check("wst_err", bus.resp_err, 1'b0);
    check("wst_ram_we_off", bus.ram_we, 1'b0);
    check("wst_ram_a_idle", bus.ram_a, 32'h0);
    finish_resp("wst");
    check("wst_one_write", wr_count - wr0, 32'd1);
    load("wld", SZ_W, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF);

    // Byte store read-modify-write into lane 2.
    wr0 = wr_count;
    accept(1'b1, SZ_B, 1'b0, 32'h0001_0002, 32'h1234_56AA);
    check("bst_read_ram_a", bus.ram_a, 32'h0001_0000);
    check("bst_read_ram_we", bus.ram_we, 1'b0);
    check("bst_read_no_resp", bus.resp_valid, 1'b0);
    step();
    check("bst_write_ram_we", bus.ram_we, 1'b1);
    check("bst_write_ram_a", bus.ram_a, 32'h0001_0000);
    check("bst_write_ram_wd", bus.ram_wd, 32'h11AA_3344);
    check("bst_write_no_resp", bus.resp_valid, 1'b0);
    step();
    check("bst_resp_valid", bus.resp_valid, 1'b1);
    check("bst_rdata_zero", bus.resp_rdata, 32'h0);
    finish_resp("bst");
    check("bst_one_write", wr_count - wr0, 32'd1);
    check("bst_mem", mem[0], 32'h11AA_3344);

    // Half store into the upper half.
    accept(1'b1, SZ_H, 1'b0, 32'h0001_0002, 32'hFFFF_BEEF);
    step();
    check("hst_ram_wd", bus.ram_wd, 32'hBEEF_3344);
    step();
    finish_resp("hst");
    check("hst_mem", mem[0], 32'hBEEF_3344);

    // Lane extraction and extension.
    poke(0, 32'h80F0_017F);
    load("ld_sb0", SZ_B, 1'b0, 32'h0001_0000, 32'h0000_007F);
    load("ld_sh2", SZ_H, 1'b0, 32'h0001_0002, 32'hFFFF_80F0);
    load("ld_ub3", SZ_B, 1'b1, 32'h0001_0003, 32'h0000_0080);
    load("ld_sb3", SZ_B, 1'b0, 32'h0001_0003, 32'hFFFF_FF80);
    load("ld_uh2", SZ_H, 1'b1, 32'h0001_0002, 32'h0000_80F0);
    load("ld_sh0", SZ_H, 1'b0, 32'h0001_0000, 32'h0000_017F);
    load("ld_sb2", SZ_B, 1'b0, 32'h0001_0002, 32'hFFFF_FFF0);

    // Misaligned and illegal requests.
    bad_req("err_half_ld", 1'b0, SZ_H, 32'h0001_0001);
    bad_req("err_word_st", 1'b1, SZ_W, 32'h0001_0006);
    bad_req("err_size11", 1'b1, SZ_X, 32'h0001_0000);
    check("err_mem1_kept", mem[1], 32'hDEAD_BEEF);
    check("err_mem0_kept", mem[0], 32'h80F0_017F);

    // Response stall with a competing request held on the bus.
    wr0 = wr_count;
    accept(1'b0, SZ_W, 1'b0, 32'h0001_0004, 32'h0);
    step();
    bus.req_we    = 1'b1;
    bus.req_size  = SZ_W;
    bus.req_addr  = 32'h0001_0004;
    bus.req_wdata = 32'h0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_resp_valid", bus.resp_valid, 1'b1);
      check("stall_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
      check("stall_req_ready", bus.req_ready, 1'b0);
      step();
    end
    bus.req_valid = 1'b0;
    finish_resp("stall");
    check("stall_no_write", wr_count - wr0, 32'd0);
    check("stall_mem1", mem[1], 32'hDEAD_BEEF);

    // Reset during the read phase of a byte store aborts it.
    poke(0, 32'h5566_7788);
    wr0 = wr_count;
    accept(1'b1, SZ_B, 1'b0, 32'h0001_0001, 32'h0000_00AA);
    check("abort_in_read", bus.ram_a, 32'h0001_0000);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ram_we", bus.ram_we, 1'b0);
    check("abort_ram_a", bus.ram_a, 32'h0);
    check("abort_req_ready", bus.req_ready, 1'b0);
    check("abort_resp_valid", bus.resp_valid, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("abort_ready_after", bus.req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_resp", bus.resp_valid, 1'b0);
      check("abort_no_we", bus.ram_we, 1'b0);
      step();
    end
    check("abort_no_write", wr_count - wr0, 32'd0);
    check("abort_mem_kept", mem[0], 32'h5566_7788);
    load("post_rst_ld", SZ_W, 1'b0, 32'h0001_0000, 32'h5566_7788);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data words and of the RAM data bus.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of the byte address.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req_valid  in  1  SHALL indicate that the requester presents an access.
REQ-006 req_ready  out  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 req_we  in  1  SHALL select the access type: 1 = store, 0 = load.
REQ-008 req_size  in  2  SHALL select the access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 req_unsigned  in  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-010 req_addr  in  ADDR_WIDTH  SHALL carry the byte address.
REQ-011 req_wdata  in  DATA_WIDTH  SHALL carry store data, right-aligned in bits [7:0], [15:0] or [31:0].
REQ-012 resp_valid  out  1  SHALL indicate that a response is pending.
REQ-013 resp_ready  in  1  SHALL indicate that the requester consumes the response.
REQ-014 resp_rdata  out  DATA_WIDTH  SHALL carry extended load data; it SHALL be 0 for stores and errors.
REQ-015 resp_err  out  1  SHALL flag a misaligned or illegal access.
REQ-016 ram_we  out  1  SHALL be the write enable of the word RAM.
REQ-017 ram_a  out  ADDR_WIDTH  SHALL be the RAM address, always word-aligned ([1:0] = 00).
REQ-018 ram_wd  out  DATA_WIDTH  SHALL be the RAM write data, little-endian byte lanes.
REQ-019 ram_rd  in  DATA_WIDTH  SHALL be the RAM read data, combinational from ram_a.

Function
REQ-020 The FSM SHALL have the states IDLE, READ, WRITE, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted when req_valid && req_ready at a clock edge, and all req_* fields SHALL be latched then.
REQ-022 A misaligned or illegal request SHALL go IDLE -> RESP with resp_err=1 and no RAM write: half with addr[0]=1, word with addr[1:0]!=00, or size 11.
REQ-023 A load SHALL go IDLE -> READ -> RESP.
REQ-024 In READ, ram_a SHALL equal {addr[31:2],2'b00} and ram_rd SHALL be captured into a word buffer.
REQ-025 A word store SHALL go IDLE -> WRITE -> RESP.
REQ-026 A byte or half store SHALL go IDLE -> READ -> WRITE -> RESP, with a read-modify-write of the addressed lanes only.
REQ-027 In WRITE, ram_we SHALL be 1 for exactly one cycle, ram_a SHALL be the aligned address and ram_wd SHALL be the merged word.
REQ-028 Byte lane SHALL be addr[1:0]; half lane SHALL be addr[1] (bits [15:0] or [31:16]).
REQ-029 Load extraction SHALL shift the selected lane to bit 0 and extend from bit 7 or 15 per req_unsigned; a word load SHALL be returned unchanged.
REQ-030 Latency from the acceptance edge to resp_valid SHALL be: error 1 cycle; load 2 cycles; word store 2 cycles; sub-word store 3 cycles.
REQ-031 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL be held stable until resp_ready; RESP -> IDLE on resp_valid && resp_ready.
REQ-032 A new request SHALL NOT be accepted in the RESP cycle: there is no back-to-back overlap.
REQ-033 Outside READ and WRITE, ram_a SHALL be 0, ram_we SHALL be 0 and ram_wd SHALL be 0.
REQ-034 Address bits above the RAM depth SHALL be passed through unmodified; decode is not this block's job.

Reset
REQ-035 Asserting rst SHALL force, immediately and asynchronously: state=IDLE, buffers=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, ram_a=0, ram_wd=0.
REQ-036 Reset asserted in READ or WRITE SHALL abort the access with no RAM write after reset assertion and no response.
REQ-037 After rst deasserts, req_ready SHALL be 1 in the first cycle.

Verification
REQ-038 Word store 0xDEADBEEF @0x10004, then word load @0x10004 -> ram_we pulses once with ram_a=0x10004; load resp_rdata=0xDEADBEEF at acceptance+2.
REQ-039 RAM word @0x10000=0x11223344; byte store 0xAA @0x10002 -> read cycle then write ram_wd=0x11AA3344; resp_valid at acceptance+3.
REQ-040 RAM word 0x80F0017F @0x10000: signed byte load @0x10000 -> 0x0000007F; signed half load @0x10002 -> 0xFFFF80F0; unsigned byte load @0x10003 -> 0x00000080.
REQ-041 Half load @0x10001 and word store @0x10006 -> resp_err=1 after 1 cycle, ram_we never asserted, RAM unchanged.
REQ-042 resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout; completion one cycle after resp_ready rises.
REQ-043 rst pulsed during the READ cycle of a byte store -> ram_we stays 0, no resp_valid, req_ready=1 after release, target word unchanged.
